// File: rtl/mem_access_unit_pkg.sv
// Shared types and constants for the memory-stage controller.
// State encoding, datapath widths and timeout-counter sizing.
package mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DATA_W      = 32;
   localparam int REG_W       = 6;
   localparam int DEF_TIMEOUT = 16;
   localparam int CNT_W       = $clog2(DEF_TIMEOUT);

   // Counter width for a given timeout; never narrower than one bit.
   function automatic int cntWidth(input int timeout);
      return (timeout <= 2) ? 1 : $clog2(timeout);
   endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory request/ack bus between the memory-stage controller (master)
// and the variable-latency data memory (slave).
interface mem_access_unit_if
   import mem_pkg::*;
#(
   parameter int ADDR_W = 16
);
   logic              memReq;
   logic              memWe;
   logic [ADDR_W-1:0] memAddr;
   logic [DATA_W-1:0] memWData;
   logic              memAck;
   logic [DATA_W-1:0] memRData;

   modport master (
      output memReq, memWe, memAddr, memWData,
      input  memAck, memRData
   );

   modport slave (
      input  memReq, memWe, memAddr, memWData,
      output memAck, memRData
   );
endinterface

// File: rtl/mem_access_unit_timeout_ctr.sv
// Ack-wait counter: cleared when an access launches, counts while enabled,
// and saturates with expired high at TIMEOUT-1.
module mem_timeout_ctr
   import mem_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);
   localparam int W = cntWidth(TIMEOUT);

   logic [W-1:0] cnt;

   assign expired = (cnt == W'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                cnt <= '0;
      else if (clr)              cnt <= '0;
      else if (en && !expired)   cnt <= cnt + 1'b1;
   end
endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage controller: launches one data-memory access per load/store,
// stalls the pipeline until ack or timeout, and feeds MEMWB.
module mem_access_unit
   import mem_pkg::*;
#(
   parameter int ADDR_W  = 16,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              validMEM,
   input  logic              memReadMEM,
   input  logic              memWriteMEM,
   input  logic              regWriteMEM,
   input  logic              memToRegMEM,
   input  logic              zeroMEM,
   input  logic              negMEM,
   input  logic [DATA_W-1:0] AluResultsMEM,
   input  logic [DATA_W-1:0] storeDataMEM,
   input  logic [REG_W-1:0]  rdMEM,
   mem_access_unit_if.master mem,
   output logic              stallMEM,
   output logic              regWriteOut,
   output logic              memToRegOut,
   output logic              zeroOut,
   output logic              negOut,
   output logic [DATA_W-1:0] AluResultsOut,
   output logic [REG_W-1:0]  rdOut,
   output logic [DATA_W-1:0] memDataOut,
   output logic              memFault
);
   state_t state, nxt;

   logic              memOp, launch, ackHit, toHit, expired, stall, regWr;
   logic              memReqQ, memWeQ;
   logic [ADDR_W-1:0] memAddrQ;
   logic [DATA_W-1:0] memWDataQ;

   assign memOp = validMEM & (memReadMEM | memWriteMEM);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt    = IDLE;
      launch = 1'b0;
      ackHit = 1'b0;
      toHit  = 1'b0;
      stall  = 1'b0;
      regWr  = 1'b0;
      case (state)
         IDLE: begin
            if (memOp) begin
               stall  = 1'b1;
               launch = 1'b1;
               nxt    = WAIT;
            end else begin
               regWr = regWriteMEM & validMEM;
            end
         end
         WAIT: begin
            stall = 1'b1;
            nxt   = WAIT;
            // An ack on the last allowed cycle still wins over the timeout.
            if (mem.memAck) begin
               ackHit = 1'b1;
               nxt    = DONE;
            end else if (expired) begin
               toHit = 1'b1;
               nxt   = DONE;
            end
         end
         DONE: begin
            regWr = regWriteMEM;
            nxt   = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   mem_timeout_ctr #(.TIMEOUT(TIMEOUT)) uCtr (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (launch),
      .en      (state == WAIT),
      .expired (expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         memReqQ    <= 1'b0;
         memWeQ     <= 1'b0;
         memAddrQ   <= '0;
         memWDataQ  <= '0;
         memDataOut <= '0;
         memFault   <= 1'b0;
      end else begin
         memFault <= toHit;
         if (launch) begin
            memReqQ   <= 1'b1;
            memWeQ    <= memWriteMEM;
            memAddrQ  <= AluResultsMEM[ADDR_W+1:2];
            memWDataQ <= storeDataMEM;
         end
         if (ackHit) begin
            memReqQ <= 1'b0;
            if (!memWeQ) memDataOut <= mem.memRData;
         end
         if (toHit) begin
            memReqQ    <= 1'b0;
            memDataOut <= '0;
         end
      end
   end

   assign mem.memReq   = memReqQ;
   assign mem.memWe    = memWeQ;
   assign mem.memAddr  = memAddrQ;
   assign mem.memWData = memWDataQ;

   // Reset must drop the stall at once, even though state decodes as IDLE.
   assign stallMEM      = stall & rst_n;
   assign regWriteOut   = regWr;
   assign memToRegOut   = memToRegMEM;
   assign zeroOut       = zeroMEM;
   assign negOut        = negMEM;
   assign AluResultsOut = AluResultsMEM;
   assign rdOut         = rdMEM;
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage controller between the EX/MEM pipeline register and MEMWB. It drives a variable-latency data memory through a req/ack handshake and stalls the pipeline while an access is outstanding. It hands MEMWB the loaded word and the pass-through control and results. Non-memory instructions pass through with zero added latency.

## Interface
- `ADDR_W`, 16: word-address width driven to data memory.
- `TIMEOUT`, 16: maximum WAIT cycles before a fault is declared (≥2).
- `clk` in 1: pipeline clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset. One clock, no other clock domains.
- `validMEM` in 1: EX/MEM holds a real instruction.
- `memReadMEM`, `memWriteMEM` in 1 each: load / store request. Both high is treated as a store.
- `regWriteMEM`, `memToRegMEM`, `zeroMEM`, `negMEM` in 1 each: control and flags for MEMWB.
- `AluResultsMEM` in 32: ALU result; byte address for memory ops.
- `storeDataMEM` in 32: store data.
- `rdMEM` in 6: destination register.
- `memReq` out 1: request to data memory.
- `memWe` out 1: write enable, qualified by `memReq`.
- `memAddr` out ADDR_W: word address = `AluResultsMEM[ADDR_W+1:2]`.
- `memWData` out 32: store data.
- `memAck` in 1: memory completion, sampled on `clk`.
- `memRData` in 32: read data, valid when `memAck`=1.
- `stallMEM` out 1: hold PC, IF/ID, ID/EX and EX/MEM this cycle.
- `regWriteOut`, `memToRegOut`, `zeroOut`, `negOut` out 1 each: to MEMWB.
- `AluResultsOut` out 32, `rdOut` out 6: to MEMWB.
- `memDataOut` out 32: load data to MEMWB.
- `memFault` out 1: one-cycle pulse when an access timed out.

## Operation
- FSM states: IDLE, WAIT, DONE.
- IDLE, no memory op (`validMEM`=0, or neither read nor write):
  - `stallMEM`=0.
  - Outputs pass through combinationally.
  - `regWriteOut = regWriteMEM & validMEM`.
- IDLE with a memory op:
  - `stallMEM`=1 and `regWriteOut`=0, so a bubble goes to MEMWB.
  - At the edge: latch `memAddr`, `memWData` and `memWe`; set `memReq`<=1; clear the timeout counter; go to WAIT.
- WAIT:
  - `stallMEM`=1, `regWriteOut`=0, `memReq` held at 1 and request fields held stable.
  - `memAck`=1 at an edge: `memReq`<=0. On a load, capture `memRData` into `memDataOut`. Go to DONE.
  - Counter reaches TIMEOUT-1 with no ack: `memReq`<=0, `memDataOut`<=0, set the fault flag, go to DONE.
- DONE:
  - `stallMEM`=0.
  - Pass-through outputs come from EX/MEM, which is still held.
  - `regWriteOut = regWriteMEM`.
  - `memDataOut` holds its captured value.
  - `memFault`=1 only if this access timed out.
  - Next edge goes to IDLE; upstream advances on that same edge.
- DONE never launches a new access. Back-to-back memory ops therefore cost one extra IDLE cycle each.
- `memAck` is ignored in IDLE and DONE.
- A stray ack after a timeout is ignored. The memory must not ack after `memReq` falls.

## Timing
- Reset (asynchronous, immediate): state=IDLE, `memReq`=0, `memWe`=0, `memAddr`=0, `memWData`=0, `memDataOut`=0, `memFault`=0, counter=0. `stallMEM` is forced 0 while `rst_n`=0.
- Reset mid-access aborts the request immediately. The access is never completed or retried.
- Load with ack in the first WAIT cycle: 2 stall cycles, then DONE. Total op latency 3 cycles; data reaches MEMWB at the DONE→IDLE edge.
- Each extra ack-wait cycle adds one stall cycle. The worst case is TIMEOUT+1 stall cycles.
- `memReq`, `memWe`, `memAddr`, `memWData`, `memDataOut` and `memFault` are registered. `stallMEM` and the pass-through outputs are combinational from state and inputs.
- Non-memory instruction latency: 0 cycles. No state change.

## Structure
- Shared package `mem_pkg`:
  - state encoding IDLE=2'd0, WAIT=2'd1, DONE=2'd2, with 2'd3 recovering to IDLE;
  - DATA_W=32 and REG_W=6 constants;
  - `$clog2(TIMEOUT)` counter-width localparam.
- One sub-module, `mem_timeout_ctr`: clear, enable, and `expired` at TIMEOUT-1, with async active-low reset.

## Test plan
- ADD, rd=5, AluResultsMEM=0x1234, `validMEM`=1 → same cycle `stallMEM`=0, `regWriteOut`=1, `rdOut`=5, `AluResultsOut`=0x1234, `memReq` stays 0.
- LW addr 0x40, ack after 3 WAIT cycles with `memRData`=0xDEADBEEF → `memAddr`=0x10. `stallMEM` high 4 cycles with `regWriteOut`=0. In DONE, `memDataOut`=0xDEADBEEF and `regWriteOut`=1.
- SW addr 0x8, data 0xCAFEF00D, immediate ack → `memWe`=1, `memAddr`=2, `memWData`=0xCAFEF00D for exactly one WAIT cycle. 2 stall cycles; `regWriteOut`=0 in DONE if `regWriteMEM`=0.
- LW with no ack, TIMEOUT=16 → `memReq` high 16 cycles then drops. DONE shows `memDataOut`=0 and a single-cycle `memFault`=1. A late ack is ignored.
- Assert `rst_n`=0 in the 2nd WAIT cycle → `memReq`, `stallMEM` and `memDataOut` are 0 before the next edge. After release, state is IDLE and the next ADD passes through unstalled.
- LW followed by LW → second request begins one cycle after the first DONE and uses the second instruction's address. No duplicate request for the first.
